// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg
//
// Shared types and constants for the SubBytes engine.
//   aes_mode_e        : selects forward or inverse substitution
//   sub_bytes_state_e : engine FSM states
//   AES_SBOX_FWD/INV  : 256-entry FIPS-197 substitution tables
//   sbox_fwd/sbox_inv : single-byte lookup helpers
//
// Both tables always live here. Whether the forward table gets built into
// hardware is decided in aes_sbox_lane by the AES_SBOX_FWD_EN macro.

package aes_sbox_pkg;

    typedef enum logic {
        AES_MODE_INV = 1'b0,
        AES_MODE_FWD = 1'b1
    } aes_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_bytes_state_e;

    localparam logic [7:0] AES_SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] AES_SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return AES_SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return AES_SBOX_INV[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// aes_sbox_lane
//
// One purely combinational S-box lane: substitutes a single byte.
//   din  : byte to substitute
//   mode : AES_MODE_FWD or AES_MODE_INV
//   dout : substituted byte
//
// Configuration macro AES_SBOX_FWD_EN:
//   defined   - forward and inverse tables are both built, mode selects.
//   undefined - only the inverse table is built and mode is ignored
//               (decrypt-only build; the port stays for a stable interface).

module aes_sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [7:0] din,
    input  aes_mode_e  mode,
    output logic [7:0] dout
);

`ifdef AES_SBOX_FWD_EN
    // Both tables are present per lane; the latched mode picks one.
    always_comb begin
        dout = (mode == AES_MODE_FWD) ? sbox_fwd(din) : sbox_inv(din);
    end
`else
    // Decrypt-only: the mode input exists but has nothing to steer.
    logic unused_mode;
    assign unused_mode = (mode == AES_MODE_FWD);

    always_comb begin
        dout = sbox_inv(din);
    end
`endif

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// aes_sub_bytes_engine
//
// Multi-lane, valid/ready SubBytes / InvSubBytes engine. A full 128-bit state
// is accepted, then LANES bytes are substituted per cycle over NBEATS =
// 16/LANES cycles, and the result is held until the consumer takes it.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous, active-high reset
//   in_valid  : input state valid
//   in_ready  : engine can accept a state (IDLE only)
//   in_data   : input state, byte i = in_data[127-8*i -: 8]
//   in_mode   : 1 = forward S-box, 0 = inverse; sampled at accept only
//   out_valid : result valid (DONE)
//   out_ready : downstream accepts result
//   out_data  : substituted state, same byte order; zero unless out_valid
//   busy      : high in BUSY or DONE
//
// Parameter LANES: 1, 2, 4, 8 or 16; anything else stops elaboration.
// Configuration macro AES_SBOX_FWD_EN (see aes_sbox_lane): when undefined the
// engine always performs InvSubBytes and in_mode has no effect.

module aes_sub_bytes_engine
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NBEATS = 16 / LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sub_bytes_state_e         state_q;
    sub_bytes_state_e         state_d;
    logic [CW-1:0]            beat_q;
    aes_mode_e                mode_q;
    // Element 0 is the most significant byte, so this packs straight from
    // in_data and byte i of the state is simply work_q[i].
    logic [0:15][7:0]         work_q;
    logic [0:15][7:0]         work_d;
    logic [LANES-1:0][7:0]    lane_in;
    logic [LANES-1:0][7:0]    lane_out;
    logic [3:0]               base;
    logic                     last_beat;

    // First byte handled this beat. With LANES=16 the counter is always zero.
    assign base      = 4'(int'(beat_q) * LANES);
    assign last_beat = (beat_q == CW'(NBEATS - 1));

    // Gather the LANES consecutive bytes belonging to the current beat.
    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[base + 4'(l)];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_lane u_lane (
            .din  (lane_in[l]),
            .mode (mode_q),
            .dout (lane_out[l])
        );
    end

    // Working state with this beat's substituted bytes merged back in.
    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[base + 4'(l)] = lane_out[l];
        end
    end

    // Next-state logic. IDLE only leaves on an actual request (in_ready is
    // implied there), and DONE never re-accepts in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, beat counter, latched mode and working register. The state is
    // captured on accept; later changes on in_data/in_mode are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            mode_q  <= AES_MODE_INV;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        mode_q <= aes_mode_e'(in_mode);
                        beat_q <= '0;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    beat_q <= last_beat ? '0 : beat_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Gate the working register so a partially substituted state is never
    // visible on the output.
    assign out_data  = (state_q == DONE) ? work_q : '0;

endmodule
